// File: rtl/mwc_pkg.sv
// mwc_pkg: shared state and verdict encodings for the mem_write_checker store monitor.
package mwc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PASS,
        FAIL
    } mwc_state_t;

    typedef enum logic [1:0] {
        MWC_FAIL_NONE    = 2'b00,
        MWC_FAIL_DATA    = 2'b01,
        MWC_FAIL_TIMEOUT = 2'b10,
        MWC_FAIL_ORDER   = 2'b11
    } mwc_fail_t;

endpackage

// File: rtl/mwc_entry_cmp.sv
// mwc_entry_cmp: address/data compare of the current store against one expectation entry.
module mwc_entry_cmp #(
    parameter int n = 32
) (
    input  logic         entry_valid,
    input  logic         entry_matched,
    input  logic [n-1:0] entry_addr,
    input  logic [n-1:0] entry_data,
    input  logic [n-1:0] dataadr,
    input  logic [n-1:0] writedata,
    output logic         addr_hit,
    output logic         data_hit
);

    // Only still-open entries can be hit; satisfied or unused entries stay silent.
    assign addr_hit = entry_valid && !entry_matched && (entry_addr == dataadr);
    assign data_hit = addr_hit && (entry_data == writedata);

endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: grades data-memory stores against a loadable expectation table.
// Build option MWC_ORDERED_EN: valid entries must be satisfied in ascending index order.
// state | meaning
// IDLE  | table loadable, waiting for start
// ARMED | watching stores, cycle counter running
// PASS  | every valid entry matched
// FAIL  | data mismatch, out-of-order store or timeout
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int  n       = 32,
    parameter int  DEPTH   = 4,
    parameter int  TIMEOUT = 1024,
    localparam int IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwrite,
    input  logic [n-1:0]  dataadr,
    input  logic [n-1:0]  writedata,
    input  logic          exp_we,
    input  logic [IW-1:0] exp_idx,
    input  logic          exp_valid,
    input  logic [n-1:0]  exp_addr,
    input  logic [n-1:0]  exp_data,
    input  logic          start,
    output logic          done,
    output logic          pass,
    output logic [1:0]    fail_code,
    output logic [IW-1:0] fail_idx,
    output logic [CW-1:0] match_count
);

    mwc_state_t       r_state;
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_matched;
    logic [n-1:0]     r_addr [DEPTH];
    logic [n-1:0]     r_data [DEPTH];
    logic [TW-1:0]    r_cnt;
    logic             r_done;
    logic             r_pass;
    mwc_fail_t        r_fail_code;
    logic [IW-1:0]    r_fail_idx;
    logic [CW-1:0]    r_match_count;

    logic [DEPTH-1:0] w_addr_hit;
    logic [DEPTH-1:0] w_data_hit;
    logic [DEPTH-1:0] w_settled;
    logic [DEPTH-1:0] w_hit_vec;
    logic             w_load;
    logic             w_match;
    logic [IW-1:0]    w_match_idx;
    logic             w_err;
    mwc_fail_t        w_err_code;
    logic [IW-1:0]    w_err_idx;
    logic             w_all;
    logic             w_timeout;
`ifdef MWC_ORDERED_EN
    logic             w_ptr_ok;
    logic [IW-1:0]    w_ptr;
`endif

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
            mwc_entry_cmp #(.n(n)) u_cmp (
                .entry_valid   (r_valid[g]),
                .entry_matched (r_matched[g]),
                .entry_addr    (r_addr[g]),
                .entry_data    (r_data[g]),
                .dataadr       (dataadr),
                .writedata     (writedata),
                .addr_hit      (w_addr_hit[g]),
                .data_hit      (w_data_hit[g])
            );
        end
    endgenerate

    // Invalid entries count as already satisfied, so the mask never needs preloading.
    assign w_settled = r_matched | ~r_valid;
    assign w_load    = (r_state == IDLE) && exp_we && (int'(exp_idx) < DEPTH);
    assign w_timeout = (r_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_err       = 1'b0;
        w_err_code  = MWC_FAIL_NONE;
        w_err_idx   = '0;
        w_hit_vec   = '0;
`ifdef MWC_ORDERED_EN
        w_ptr_ok = 1'b0;
        w_ptr    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!w_settled[i]) begin
                w_ptr_ok = 1'b1;
                w_ptr    = IW'(i);
            end
        end
        if (memwrite && w_ptr_ok && w_addr_hit[w_ptr]) begin
            if (w_data_hit[w_ptr]) begin
                w_match     = 1'b1;
                w_match_idx = w_ptr;
            end else begin
                w_err      = 1'b1;
                w_err_code = MWC_FAIL_DATA;
                w_err_idx  = w_ptr;
            end
        end else if (memwrite) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_addr_hit[i]) begin
                    w_err      = 1'b1;
                    w_err_code = MWC_FAIL_ORDER;
                    w_err_idx  = IW'(i);
                end
            end
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_data_hit[i]) w_match_idx = IW'(i);
            if (w_addr_hit[i]) w_err_idx = IW'(i);
        end
        w_match = memwrite && (|w_data_hit);
        if (memwrite && !w_match && (|w_addr_hit)) begin
            w_err      = 1'b1;
            w_err_code = MWC_FAIL_DATA;
        end
`endif
        w_hit_vec[w_match_idx] = w_match;
        w_all = &(w_settled | w_hit_vec);
    end

    always_ff @(posedge clk) begin
        if (w_load) begin
            r_addr[exp_idx] <= exp_addr;
            r_data[exp_idx] <= exp_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_valid       <= '0;
            r_matched     <= '0;
            r_cnt         <= '0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail_code   <= MWC_FAIL_NONE;
            r_fail_idx    <= '0;
            r_match_count <= '0;
        end else begin
            if (w_load) r_valid[exp_idx] <= exp_valid;
            if (start) begin
                r_state       <= ARMED;
                r_matched     <= '0;
                r_cnt         <= '0;
                r_done        <= 1'b0;
                r_pass        <= 1'b0;
                r_fail_code   <= MWC_FAIL_NONE;
                r_fail_idx    <= '0;
                r_match_count <= '0;
            end else if (r_state == ARMED) begin
                if (w_err) begin
                    r_state     <= FAIL;
                    r_done      <= 1'b1;
                    r_fail_code <= w_err_code;
                    r_fail_idx  <= w_err_idx;
                end else begin
                    r_matched <= r_matched | w_hit_vec;
                    if (w_match) r_match_count <= r_match_count + CW'(1);
                    if (w_all) begin
                        r_state <= PASS;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state     <= FAIL;
                        r_done      <= 1'b1;
                        r_fail_code <= MWC_FAIL_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
            end
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail_code   = r_fail_code;
    assign fail_idx    = r_fail_idx;
    assign match_count = r_match_count;

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed and randomized scoreboard bench for mem_write_checker.
module tb_mem_write_checker;

    localparam int N       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int IW      = 2;
    localparam int CW      = 3;
    localparam int MAXS    = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          memwrite = 1'b0;
    logic [N-1:0]  dataadr = '0;
    logic [N-1:0]  writedata = '0;
    logic          exp_we = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic          exp_valid = 1'b0;
    logic [N-1:0]  exp_addr = '0;
    logic [N-1:0]  exp_data = '0;
    logic          start = 1'b0;
    logic          done;
    logic          pass;
    logic [1:0]    fail_code;
    logic [IW-1:0] fail_idx;
    logic [CW-1:0] match_count;

    mem_write_checker #(.n(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
        .start(start), .done(done), .pass(pass), .fail_code(fail_code),
        .fail_idx(fail_idx), .match_count(match_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit ps;
        int code;
        int idx;
        int mc;
        int vcyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference copy of the table and of the store program for the next run.
    bit          m_valid [DEPTH];
    int unsigned m_addr  [DEPTH];
    int unsigned m_data  [DEPTH];
    bit          s_we    [MAXS];
    int unsigned s_addr  [MAXS];
    int unsigned s_data  [MAXS];
    int          s_len = 0;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic exp_t mk(bit ps, int code, int idx, int mc, int k);
        exp_t e;
        e.ps = ps; e.code = code; e.idx = idx; e.mc = mc; e.vcyc = k;
        return e;
    endfunction

    // Walks the store program one ARMED cycle at a time using set semantics.
    function automatic exp_t model();
        bit sat [DEPTH];
        int cnt;
        bit all;
`ifdef MWC_ORDERED_EN
        int p, other;
`else
        int hit, cand;
`endif
        cnt = 0;
        for (int i = 0; i < DEPTH; i++) sat[i] = !m_valid[i];
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k < s_len && s_we[k]) begin
`ifdef MWC_ORDERED_EN
                p = -1; other = -1;
                for (int i = 0; i < DEPTH; i++) if (p < 0 && !sat[i]) p = i;
                for (int i = 0; i < DEPTH; i++)
                    if (other < 0 && i != p && !sat[i] && m_addr[i] == s_addr[k]) other = i;
                if (p >= 0 && m_addr[p] == s_addr[k]) begin
                    if (m_data[p] == s_data[k]) begin sat[p] = 1'b1; cnt++; end
                    else return mk(1'b0, 1, p, cnt, k);
                end else if (other >= 0) begin
                    return mk(1'b0, 3, other, cnt, k);
                end
`else
                hit = -1; cand = -1;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!sat[i] && m_addr[i] == s_addr[k]) begin
                        if (cand < 0) cand = i;
                        if (hit < 0 && m_data[i] == s_data[k]) hit = i;
                    end
                end
                if (hit >= 0) begin sat[hit] = 1'b1; cnt++; end
                else if (cand >= 0) return mk(1'b0, 1, cand, cnt, k);
`endif
            end
            all = 1'b1;
            for (int i = 0; i < DEPTH; i++) if (!sat[i]) all = 1'b0;
            if (all) return mk(1'b1, 0, 0, cnt, k);
            if (k == TIMEOUT - 1) return mk(1'b0, 2, 0, cnt, k);
        end
        return mk(1'b0, 2, 0, cnt, TIMEOUT - 1);
    endfunction

    // Monitor: pops one expectation for every rising edge of done.
    initial begin : monitor
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && prev_done !== 1'b1) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_verdict: got done=1 at cycle %0d, want none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("pass", int'(pass), int'(e.ps));
                    chk("fail_code", int'(fail_code), e.code);
                    chk("fail_idx", int'(fail_idx), e.idx);
                    chk("match_count", int'(match_count), e.mc);
                    chk("verdict_cycle", cyc, e.vcyc);
                end
            end
            prev_done = done;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; memwrite = 1'b0; exp_we = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass"}, int'(pass), 0);
        chk({tag, "_code"}, int'(fail_code), 0);
        chk({tag, "_idx"}, int'(fail_idx), 0);
        chk({tag, "_mc"}, int'(match_count), 0);
    endtask

    task automatic load(input int i, input bit v, input int unsigned a, input int unsigned d);
        @(negedge clk);
        exp_we = 1'b1; exp_idx = IW'(i); exp_valid = v; exp_addr = a; exp_data = d;
        m_valid[i] = v; m_addr[i] = a; m_data[i] = d;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    task automatic clr_prog();
        s_len = 0;
    endtask

    task automatic add_st(input bit we, input int unsigned a, input int unsigned d);
        s_we[s_len] = we; s_addr[s_len] = a; s_data[s_len] = d;
        s_len++;
    endtask

    task automatic run_prog(input exp_t e, input bit chk_clear, input bit junk);
        @(negedge clk);
        start = 1'b1;
        e.vcyc = cyc + 2 + e.vcyc;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        if (chk_clear) chk_zero("rearm");
        for (int k = 0; k < s_len; k++) begin
            memwrite = s_we[k]; dataadr = s_addr[k]; writedata = s_data[k];
            if (junk) begin
                exp_we = 1'($urandom_range(0, 1)); exp_idx = IW'($urandom_range(0, 3));
                exp_valid = 1'b1; exp_addr = 4 * $urandom_range(0, 3);
                exp_data = $urandom_range(0, 3);
            end
            @(negedge clk);
        end
        memwrite = 1'b0; exp_we = 1'b0;
        for (int w = 0; w < 3 * TIMEOUT && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL verdict_wait: got no verdict, want one by cycle %0d", sb[0].vcyc);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int r;
        do_reset();
        chk_zero("reset");

        // Single entry, single matching store.
        load(0, 1'b1, 84, 'h96);
        clr_prog(); add_st(1'b1, 84, 'h96);
        run_prog(mk(1'b1, 0, 0, 1, 0), 1'b0, 1'b0);

        // Two entries hit in reverse index order.
        do_reset();
        load(0, 1'b1, 84, 'h96); load(1, 1'b1, 88, 'h7);
        clr_prog(); add_st(1'b1, 88, 'h7); add_st(1'b1, 84, 'h96);
`ifdef MWC_ORDERED_EN
        run_prog(mk(1'b0, 3, 1, 0, 0), 1'b0, 1'b0);
`else
        run_prog(mk(1'b1, 0, 0, 2, 1), 1'b0, 1'b0);
`endif

        // Unexpected address ignored, then wrong data on a tracked address.
        do_reset();
        load(0, 1'b1, 84, 'h96);
        clr_prog(); add_st(1'b1, 40, 'h1); add_st(1'b1, 84, 'h95);
        run_prog(mk(1'b0, 1, 0, 0, 1), 1'b0, 1'b0);

        // Re-arm from FAIL keeps the table; the correct store now passes.
        clr_prog(); add_st(1'b1, 84, 'h96);
        run_prog(mk(1'b1, 0, 0, 1, 0), 1'b1, 1'b0);

        // Timeout with no stores, then completion on the last allowed cycle.
        do_reset();
        load(0, 1'b1, 84, 'h96);
        clr_prog();
        run_prog(mk(1'b0, 2, 0, 0, TIMEOUT - 1), 1'b0, 1'b0);
        clr_prog();
        for (int k = 0; k < TIMEOUT - 1; k++) add_st(1'b0, 0, 0);
        add_st(1'b1, 84, 'h96);
        run_prog(mk(1'b1, 0, 0, 1, TIMEOUT - 1), 1'b1, 1'b0);

        // Reset mid-run after one of two matches; the cleared table passes at once.
        do_reset();
        load(0, 1'b1, 84, 'h96); load(1, 1'b1, 88, 'h7);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; memwrite = 1'b1; dataadr = 84; writedata = 'h96;
        @(negedge clk); memwrite = 1'b0;
        chk("mid_match_count", int'(match_count), 1);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        #1;
        chk_zero("midreset");
        @(negedge clk); reset = 1'b0;
        clr_prog();
        run_prog(mk(1'b1, 0, 0, 0, 0), 1'b0, 1'b0);

        // Randomized tables and store programs against the reference model.
        for (r = 0; r < 80; r++) begin
            do_reset();
            chk("rnd_reset_done", int'(done), 0);
            for (int i = 0; i < DEPTH; i++)
                load(i, $urandom_range(0, 3) != 0, 4 * $urandom_range(0, 3), $urandom_range(0, 3));
            for (int pass_no = 0; pass_no < 2; pass_no++) begin
                int sel, j;
                clr_prog();
                for (int k = 0; k < int'($urandom_range(0, 9)); k++) begin
                    sel = $urandom_range(0, 9);
                    j = $urandom_range(0, DEPTH - 1);
                    if (sel < 6)
                        add_st(1'b1, m_addr[j], (sel < 5) ? m_data[j] : $urandom_range(0, 3));
                    else if (sel < 8)
                        add_st(1'b1, 4 * $urandom_range(0, 5), $urandom_range(0, 3));
                    else
                        add_st(1'b0, 0, 0);
                end
                run_prog(model(), pass_no == 1, 1'b1);
            end
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
# mem_write_checker

- Synthesizable self-checking monitor for the single-cycle MIPS computer.
- Passively watches the data-memory write port (`memwrite`, `dataadr`, `writedata`).
- Holds a loadable table of DEPTH expected (address, data) stores and grades the run as pass or fail.
- A bounded cycle timeout replaces a fixed `$finish`, so one bench instance can grade any program.

## Interface
- `n`, 32: width of `dataadr` and `writedata`.
- `DEPTH`, 4: number of expectation entries (≥1).
- `TIMEOUT`, 1024: maximum ARMED cycles before failure (≥1).
- `clk`  in  1  system clock; all state updates on its posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `memwrite`  in  1  data-memory write strobe from the computer.
- `dataadr`  in  n  store address.
- `writedata`  in  n  store data.
- `exp_we`  in  1  write one expectation entry (honoured only in IDLE).
- `exp_idx`  in  $clog2(DEPTH)  entry index to write.
- `exp_valid`  in  1  valid bit stored with the entry.
- `exp_addr`  in  n  expected address.
- `exp_data`  in  n  expected data.
- `start`  in  1  arm the checker.
- `done`  out  1  verdict reached (PASS or FAIL).
- `pass`  out  1  all valid entries matched.
- `fail_code`  out  2  00 none, 01 data mismatch, 10 timeout, 11 out-of-order.
- `fail_idx`  out  $clog2(DEPTH)  entry that caused a mismatch or out-of-order failure; 0 otherwise.
- `match_count`  out  $clog2(DEPTH+1)  entries matched so far.

## Operation
- States: IDLE, ARMED, PASS, FAIL.
- Reset values: IDLE; every output 0; table valid bits cleared; matched mask 0; cycle counter 0.
- IDLE → ARMED on `start`.
  - Loading: `exp_we` writes entry `exp_idx`. It is ignored in ARMED, PASS and FAIL.
- Arming (entry into ARMED from any state, or a restart):
  - Clear the matched mask, `match_count` and the cycle counter.
  - Clear `done`, `pass`, `fail_code` and `fail_idx`.
  - Invalid entries count as pre-matched.
- ARMED, on each posedge with `memwrite` = 1 (unordered mode):
  - Candidates: valid, unmatched entries whose address equals `dataadr`.
  - If any candidate's data equals `writedata`, mark the lowest such index matched and increment `match_count`.
  - Else, if candidates exist → FAIL, code 01, `fail_idx` = lowest candidate index.
  - No candidates: store ignored (unexpected addresses are legal).
- Completion: every valid entry matched → PASS (`done` = 1, `pass` = 1).
  - An empty table (no valid entries) reaches PASS on the first ARMED cycle.
- Timeout: the cycle counter increments every ARMED cycle.
  - When the counter reaches TIMEOUT-1 without completion → FAIL, code 10.
- `start` in ARMED restarts (re-arms). `start` in PASS or FAIL re-arms.
- PASS and FAIL otherwise hold their state and outputs.

## Timing
- All outputs are registered.
- The verdict is visible the cycle after the deciding store's posedge.
- `match_count` updates one cycle after the store.
- Same-cycle priority, highest first:
  1. `reset`
  2. `start`
  3. Mismatch / out-of-order failure
  4. Completion (PASS)
  5. Timeout
- Consequence: a completing store on the timeout cycle yields PASS.
- `reset` asserted mid-run returns to IDLE immediately, asynchronously. The table must be reloaded.
- `memwrite` is sampled only in ARMED. Stores in other states have no effect.

## Configuration
- Macro `MWC_ORDERED_EN`.
- Defined:
  - Valid entries must be satisfied in ascending index order. A pointer tracks the lowest unmatched valid entry.
  - Store to the pointer's address with matching data → advance the pointer.
  - Same address, wrong data → FAIL, code 01.
  - Store to the address of any other unmatched valid entry → FAIL, code 11, `fail_idx` = that entry.
- Undefined: unordered matching as above. Code 11 is never produced.

## Structure
- Package `mwc_pkg`:
  - `mwc_state_t` enum: IDLE, ARMED, PASS, FAIL.
  - `mwc_fail_t` enum with the four `fail_code` values.
  - Constants `MWC_FAIL_NONE`, `MWC_FAIL_DATA`, `MWC_FAIL_TIMEOUT`, `MWC_FAIL_ORDER`.
- Sub-module `mwc_entry_cmp`:
  - One instance per entry, generated DEPTH times.
  - Inputs: entry fields, matched bit, `dataadr`, `writedata`.
  - Outputs: `addr_hit` and `data_hit`.
  - Purely combinational.
- The top level owns the FSM, priority encoders, matched mask and counter.

## Test plan
- Single entry: load entry 0 = (84, 0x96), start, store (84, 0x96) → `pass` = 1, `done` = 1, `match_count` = 1 one cycle later.
- Two entries (84, 0x96), (88, 0x7), unordered; stores 88 then 84 → PASS. With `MWC_ORDERED_EN`, the same sequence → FAIL code 11, `fail_idx` = 1.
- Wrong data: entry (84, 0x96), store (84, 0x95) → FAIL code 01, `fail_idx` = 0. A prior store (40, 0x1) is ignored.
- Timeout: TIMEOUT = 8, one valid entry, no stores → FAIL code 10 after 8 ARMED cycles.
  - Variant: the completing store on cycle 8 → PASS.
- Reset mid-run: after 1 of 2 matches, pulse `reset` → all outputs 0 and state IDLE. `start` without reload → immediate PASS (empty table).
- Re-arm: from FAIL, assert `start` → outputs cleared, `match_count` = 0. A correct store sequence then → PASS.
